// File: rtl/turf_acknack_pkg.sv
// Shared definitions for the acknack stream: field positions, the dispatcher
// state encoding and a packed view of one 48-bit acknack entry.
package turf_acknack_pkg;

    localparam int ACKNACK_WIDTH     = 48;
    localparam int ACKNACK_ALLOW_BIT = 47;
    localparam int ACKNACK_FULL_BIT  = 46;
    localparam int ACKNACK_RSVD_LSB  = 43;
    localparam int ACKNACK_RSVD_BITS = 3;
    localparam int ACKNACK_CNT_LSB   = 32;
    localparam int ACKNACK_CNT_BITS  = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_REREAD  = 2'd2,
        ST_EXPAND  = 2'd3
    } state_e;

    // Field layout of one acknack entry, MSB first.
    typedef struct packed {
        logic        allow;
        logic        full;
        logic [2:0]  rsvd;
        logic [10:0] cnt;
        logic [11:0] addr;
        logic [19:0] off;
    } acknack_t;

endpackage

// File: rtl/turf_acknack_expander.sv
// Fragment index generator for a full-event NACK. It holds the fragment count
// and the current index, and presents the index/last flag the dispatcher
// should register for the next beat (either the first beat on load, or the
// following beat on advance).
module turf_acknack_expander
    import turf_acknack_pkg::*;
(
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        load,
    input  logic [ACKNACK_CNT_BITS-1:0] cnt_in,
    input  logic                        advance,
    output logic [ACKNACK_CNT_BITS-1:0] idx_nxt,
    output logic                        last_nxt
);

    logic [ACKNACK_CNT_BITS-1:0] idx_r;
    logic [ACKNACK_CNT_BITS-1:0] cnt_r;
    logic [ACKNACK_CNT_BITS-1:0] idx_inc_s;
    logic [ACKNACK_CNT_BITS-1:0] cnt_dec_s;

    assign idx_inc_s = idx_r + 11'd1;
    assign cnt_dec_s = cnt_r - 11'd1;

    // Index and last flag of the beat that follows the current decision.
    always_comb begin
        idx_nxt  = idx_inc_s;
        last_nxt = 1'b0;
        if (load) begin
            idx_nxt  = 11'd0;
            last_nxt = (cnt_in == 11'd1);
        end else begin
            idx_nxt  = idx_inc_s;
            last_nxt = (idx_inc_s == cnt_dec_s);
        end
    end

    // Capture the count on load and step the index on every accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx_r <= 11'd0;
            cnt_r <= 11'd0;
        end else if (load) begin
            idx_r <= 11'd0;
            cnt_r <= cnt_in;
        end else if (advance) begin
            idx_r <= idx_inc_s;
        end
    end

endmodule

// File: rtl/turf_acknack_dispatch.sv
// Decodes acknack entries into buffer-release requests and fragment re-read
// requests, expanding full-event NACKs into one re-read per fragment, and
// keeps wrap-around ack/nack statistics. All outputs are registered.
module turf_acknack_dispatch
    import turf_acknack_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int FRAG_BITS = 20,
    parameter int CNT_BITS  = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ACKNACK_WIDTH-1:0]       s_acknack_tdata,
    input  logic                           s_acknack_tvalid,
    output logic                           s_acknack_tready,
    output logic [ADDR_BITS-1:0]           m_release_tdata,
    output logic                           m_release_tvalid,
    input  logic                           m_release_tready,
    output logic [ADDR_BITS+FRAG_BITS-1:0] m_reread_tdata,
    output logic                           m_reread_tvalid,
    input  logic                           m_reread_tready,
    output logic                           m_reread_tlast,
    input  logic                           flush_i,
    output logic [CNT_BITS-1:0]            ack_count_o,
    output logic [CNT_BITS-1:0]            nack_count_o,
    output logic [CNT_BITS-1:0]            empty_nack_count_o
);

    state_e                        state_r, state_nxt_s;
    logic                          tready_r;
    logic                          rel_valid_r, rr_valid_r, rr_last_r;
    logic [ADDR_BITS-1:0]          rel_data_r, rel_data_nxt_s, addr_r;
    logic [ADDR_BITS+FRAG_BITS-1:0] rr_data_r, rr_data_nxt_s;
    logic                          rr_last_nxt_s;
    logic [CNT_BITS-1:0]           ack_cnt_r, nack_cnt_r, empty_cnt_r;

    logic                          in_hs_s, rel_hs_s, rr_hs_s;
    logic                          allow_in_s, full_in_s, empty_in_s;
    logic [ADDR_BITS-1:0]          addr_in_s;
    logic [FRAG_BITS-1:0]          off_in_s;
    logic [ACKNACK_CNT_BITS-1:0]   cnt_in_s, exp_idx_s;
    logic                          exp_load_s, exp_adv_s, exp_last_s;
    logic                          rsvd_unused_s;

    assign allow_in_s    = s_acknack_tdata[ACKNACK_ALLOW_BIT];
    assign full_in_s     = s_acknack_tdata[ACKNACK_FULL_BIT];
    assign cnt_in_s      = s_acknack_tdata[ACKNACK_CNT_LSB +: ACKNACK_CNT_BITS];
    assign addr_in_s     = s_acknack_tdata[FRAG_BITS +: ADDR_BITS];
    assign off_in_s      = s_acknack_tdata[FRAG_BITS-1:0];
    assign rsvd_unused_s = ^s_acknack_tdata[ACKNACK_RSVD_LSB +: ACKNACK_RSVD_BITS];
    assign empty_in_s    = full_in_s && (cnt_in_s == 11'd0);

    assign in_hs_s  = s_acknack_tvalid && tready_r;
    assign rel_hs_s = rel_valid_r && m_release_tready;
    assign rr_hs_s  = rr_valid_r && m_reread_tready;

    turf_acknack_expander u_expander (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (exp_load_s),
        .cnt_in   (cnt_in_s),
        .advance  (exp_adv_s),
        .idx_nxt  (exp_idx_s),
        .last_nxt (exp_last_s)
    );

    // Next-state decode; the allow bit dominates the full-nack bit.
    always_comb begin
        state_nxt_s = state_r;
        exp_load_s  = 1'b0;
        exp_adv_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!in_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (allow_in_s) begin
                    state_nxt_s = ST_RELEASE;
                end else if (!full_in_s) begin
                    state_nxt_s = ST_REREAD;
                end else if (!empty_in_s) begin
                    state_nxt_s = ST_EXPAND;
                    exp_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (rel_hs_s) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_RELEASE;
            end
            ST_REREAD: begin
                if (rr_hs_s) state_nxt_s = ST_IDLE;
                else         state_nxt_s = ST_REREAD;
            end
            ST_EXPAND: begin
                // A flush wins over continuing; a coincident handshake still counts.
                if ((rr_hs_s && rr_last_r) || flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (rr_hs_s) begin
                    state_nxt_s = ST_EXPAND;
                    exp_adv_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_EXPAND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next payload for the output registers; held unchanged while stalled.
    always_comb begin
        rel_data_nxt_s = rel_data_r;
        rr_data_nxt_s  = rr_data_r;
        rr_last_nxt_s  = rr_last_r;
        if (state_r == ST_IDLE && in_hs_s) begin
            if (allow_in_s) begin
                rel_data_nxt_s = addr_in_s;
            end else if (!full_in_s) begin
                rr_data_nxt_s = {addr_in_s, off_in_s};
                rr_last_nxt_s = 1'b1;
            end else begin
                rr_data_nxt_s = {addr_in_s, {(FRAG_BITS-ACKNACK_CNT_BITS){1'b0}}, exp_idx_s};
                rr_last_nxt_s = exp_last_s;
            end
        end else if (exp_adv_s) begin
            rr_data_nxt_s = {addr_r, {(FRAG_BITS-ACKNACK_CNT_BITS){1'b0}}, exp_idx_s};
            rr_last_nxt_s = exp_last_s;
        end else begin
            rr_last_nxt_s = rr_last_r;
        end
    end

    // State, registered outputs, captured address and statistics counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            tready_r    <= 1'b1;
            rel_valid_r <= 1'b0;
            rr_valid_r  <= 1'b0;
            rr_last_r   <= 1'b0;
            rel_data_r  <= '0;
            rr_data_r   <= '0;
            addr_r      <= '0;
            ack_cnt_r   <= '0;
            nack_cnt_r  <= '0;
            empty_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            tready_r    <= (state_nxt_s == ST_IDLE);
            rel_valid_r <= (state_nxt_s == ST_RELEASE);
            rr_valid_r  <= (state_nxt_s == ST_REREAD) || (state_nxt_s == ST_EXPAND);
            rr_last_r   <= rr_last_nxt_s;
            rel_data_r  <= rel_data_nxt_s;
            rr_data_r   <= rr_data_nxt_s;
            if (state_r == ST_IDLE && in_hs_s) begin
                addr_r <= addr_in_s;
                if (allow_in_s)      ack_cnt_r   <= ack_cnt_r + CNT_BITS'(1);
                else if (empty_in_s) empty_cnt_r <= empty_cnt_r + CNT_BITS'(1);
                else                 nack_cnt_r  <= nack_cnt_r + CNT_BITS'(1);
            end
        end
    end

    assign s_acknack_tready   = tready_r;
    assign m_release_tdata    = rel_data_r;
    assign m_release_tvalid   = rel_valid_r;
    assign m_reread_tdata     = rr_data_r;
    assign m_reread_tvalid    = rr_valid_r;
    assign m_reread_tlast     = rr_last_r;
    assign ack_count_o        = ack_cnt_r;
    assign nack_count_o       = nack_cnt_r;
    assign empty_nack_count_o = empty_cnt_r;

endmodule

// File: tb/tb_turf_acknack_dispatch.sv
// Directed bench for turf_acknack_dispatch with hand-computed expectations.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_turf_acknack_dispatch;

    logic        aclk;
    logic        aresetn;
    logic [47:0] s_acknack_tdata;
    logic        s_acknack_tvalid;
    logic        s_acknack_tready;
    logic [11:0] m_release_tdata;
    logic        m_release_tvalid;
    logic        m_release_tready;
    logic [31:0] m_reread_tdata;
    logic        m_reread_tvalid;
    logic        m_reread_tready;
    logic        m_reread_tlast;
    logic        flush_i;
    logic [15:0] ack_count_o;
    logic [15:0] nack_count_o;
    logic [15:0] empty_nack_count_o;

    int n_cmp = 0;
    int n_bad = 0;
    int rr_beats = 0;

    turf_acknack_dispatch dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_acknack_tdata    (s_acknack_tdata),
        .s_acknack_tvalid   (s_acknack_tvalid),
        .s_acknack_tready   (s_acknack_tready),
        .m_release_tdata    (m_release_tdata),
        .m_release_tvalid   (m_release_tvalid),
        .m_release_tready   (m_release_tready),
        .m_reread_tdata     (m_reread_tdata),
        .m_reread_tvalid    (m_reread_tvalid),
        .m_reread_tready    (m_reread_tready),
        .m_reread_tlast     (m_reread_tlast),
        .flush_i            (flush_i),
        .ack_count_o        (ack_count_o),
        .nack_count_o       (nack_count_o),
        .empty_nack_count_o (empty_nack_count_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Count accepted re-read beats.
    always @(posedge aclk) begin
        if (aresetn && m_reread_tvalid && m_reread_tready) rr_beats <= rr_beats + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Present one entry for exactly one cycle (caller ensures tready is high).
    task automatic send(input logic [47:0] d);
        s_acknack_tdata  = d;
        s_acknack_tvalid = 1'b1;
        step();
        s_acknack_tvalid = 1'b0;
    endtask

    initial begin
        s_acknack_tdata  = 48'h0;
        s_acknack_tvalid = 1'b0;
        m_release_tready = 1'b0;
        m_reread_tready  = 1'b0;
        flush_i          = 1'b0;
        aresetn          = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check_val("rst_rel_valid", 64'(m_release_tvalid), 64'd0);
        check_val("rst_rr_valid", 64'(m_reread_tvalid), 64'd0);
        check_val("rst_counts", {16'd0, ack_count_o, nack_count_o, empty_nack_count_o}, 64'd0);
        check_val("rst_tready", 64'(s_acknack_tready), 64'd1);
        #9 aresetn = 1'b1;
        step();

        // ACK: release addr 0x0AB one cycle after handshake
        m_release_tready = 1'b1;
        send(48'h8000_0ABC_DEF1);
        check_val("ack_rel_valid", 64'(m_release_tvalid), 64'd1);
        check_val("ack_rel_data", 64'(m_release_tdata), 64'h0AB);
        check_val("ack_no_rr", 64'(m_reread_tvalid), 64'd0);
        check_val("ack_count", 64'(ack_count_o), 64'd1);
        check_val("ack_busy", 64'(s_acknack_tready), 64'd0);
        step();
        check_val("ack_done", {62'd0, m_release_tvalid, s_acknack_tready}, 64'b01);

        // Single NACK with stalls; flush must not disturb REREAD
        m_reread_tready = 1'b0;
        send(48'h0000_1230_0040);
        check_val("snack_valid", {62'd0, m_reread_tvalid, m_reread_tlast}, 64'b11);
        check_val("snack_data", 64'(m_reread_tdata), 64'h1230_0040);
        check_val("snack_count", 64'(nack_count_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_val("snack_stall_valid", 64'(m_reread_tvalid), 64'd1);
        check_val("snack_stall_data", 64'(m_reread_tdata), 64'h1230_0040);
        m_reread_tready = 1'b1;
        step();
        check_val("snack_done", {62'd0, m_reread_tvalid, s_acknack_tready}, 64'b01);
        check_val("snack_beats", 64'(rr_beats), 64'd1);

        // Full NACK addr 0x7FF, cnt 4
        send(48'h4004_7FF0_0000);
        for (int i = 0; i < 4; i++) begin
            check_val("full4_valid", 64'(m_reread_tvalid), 64'd1);
            check_val("full4_data", 64'(m_reread_tdata), 64'h7FF0_0000 + 64'(i));
            check_val("full4_last", 64'(m_reread_tlast), (i == 3) ? 64'd1 : 64'd0);
            check_val("full4_busy", 64'(s_acknack_tready), 64'd0);
            step();
        end
        check_val("full4_done", {62'd0, m_reread_tvalid, s_acknack_tready}, 64'b01);
        check_val("full4_beats", 64'(rr_beats), 64'd5);
        check_val("full4_nack_count", 64'(nack_count_o), 64'd2);

        // Full NACK cnt 0: no output, next ACK accepted immediately
        send(48'h4000_1110_0000);
        check_val("empty_no_out", {62'd0, m_reread_tvalid, m_release_tvalid}, 64'd0);
        check_val("empty_count", 64'(empty_nack_count_o), 64'd1);
        check_val("empty_nack_same", 64'(nack_count_o), 64'd2);
        check_val("empty_ready", 64'(s_acknack_tready), 64'd1);
        send(48'h8000_5550_0000);
        check_val("empty_next_ack", {51'd0, m_release_tvalid, m_release_tdata}, {51'd0, 1'b1, 12'h555});
        check_val("empty_next_count", 64'(ack_count_o), 64'd2);
        step();

        // Full NACK cnt 100, flush after 10 handshakes while stalled
        send(48'h4064_3210_0000);
        repeat (10) step();
        check_val("flush_beats_pre", 64'(rr_beats), 64'd15);
        check_val("flush_data_pre", 64'(m_reread_tdata), 64'h3210_000A);
        m_reread_tready = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_val("flush_idle", {62'd0, m_reread_tvalid, s_acknack_tready}, 64'b01);
        check_val("flush_beats", 64'(rr_beats), 64'd15);
        check_val("flush_nack_count", 64'(nack_count_o), 64'd3);
        m_reread_tready = 1'b1;
        send(48'h0000_4560_0007);
        check_val("post_flush_data", {31'd0, m_reread_tvalid, m_reread_tdata}, {31'd0, 1'b1, 32'h4560_0007});
        check_val("post_flush_last", 64'(m_reread_tlast), 64'd1);
        step();

        // Empty-NACK counter wrap, back to back at one per cycle
        s_acknack_tdata  = 48'h4000_0000_0000;
        s_acknack_tvalid = 1'b1;
        repeat (65534) step();
        check_val("wrap_max", 64'(empty_nack_count_o), 64'hFFFF);
        step();
        s_acknack_tvalid = 1'b0;
        check_val("wrap_zero", 64'(empty_nack_count_o), 64'd0);

        // ACK with full bit also set is a release; reset mid-RELEASE
        m_release_tready = 1'b0;
        send(48'hC005_2340_0000);
        check_val("ackfull_rel", {51'd0, m_release_tvalid, m_release_tdata}, {51'd0, 1'b1, 12'h234});
        check_val("ackfull_no_rr", 64'(m_reread_tvalid), 64'd0);
        check_val("ackfull_count", 64'(ack_count_o), 64'd3);
        step();
        check_val("ackfull_hold", 64'(m_release_tvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check_val("midrst_valids", {62'd0, m_release_tvalid, m_reread_tvalid}, 64'd0);
        check_val("midrst_counts", {16'd0, ack_count_o, nack_count_o, empty_nack_count_o}, 64'd0);
        #1 aresetn = 1'b1;
        m_release_tready = 1'b1;
        step();
        check_val("midrst_idle", {62'd0, m_release_tvalid, s_acknack_tready}, 64'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
